// File: rtl/vc_output_scheduler_pkg.sv
// Shared types for the VC output scheduler: credit-count width, bank flag struct, lock state.
package vc_output_scheduler_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int N_VC_DEF    = 4;
  localparam int CREDITS_DEF = 3;
  localparam int CNT_W       = clog2(CREDITS_DEF + 1);

  // Deeper downstream buffers need CREDITS_DEF raised so the counter is wide enough.
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_state_t;

endpackage

// File: rtl/vc_output_scheduler_if.sv
// Bank/link-facing signal bundle of the VC output scheduler.
interface vc_output_scheduler_if
  import vc_output_scheduler_pkg::*;
#(
  parameter int n = N_VC_DEF
);
  localparam int VW = (clog2(n) < 1) ? 1 : clog2(n);

  logic [n-1:0]  vc_empty;
  logic          head_tail;
  logic          out_ready;
  logic          credit_valid;
  logic [VW-1:0] credit_vc;
  logic [n-1:0]  select;
  logic [n-1:0]  pop;
  logic          flit_valid;
  logic [VW-1:0] out_vc;

  modport master (
    input  vc_empty, head_tail, out_ready, credit_valid, credit_vc,
    output select, pop, flit_valid, out_vc
  );

  modport slave (
    output vc_empty, head_tail, out_ready, credit_valid, credit_vc,
    input  select, pop, flit_valid, out_vc
  );
endinterface

// File: rtl/vc_output_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the one-hot pointer.
module vc_rr_arbiter #(
  parameter int n = 4
) (
  input  logic [n-1:0] req,
  input  logic [n-1:0] ptr,
  output logic [n-1:0] grant
);

  int idx;

  // Walk offsets from far to near so the closest requester is the last write.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int s = 0; s < n; s++) begin
      if (ptr[s]) begin
        for (int k = n - 1; k >= 0; k--) begin
          idx = (s + k) % n;
          if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Per-link VC scheduler: credit tracking, round-robin pick, wormhole packet lock.
// Packet lock is built only when VC_SCHED_WORMHOLE_LOCK_EN is defined; otherwise flit-level RR.
//
// state   | meaning
// LK_OPEN | no packet in flight; round-robin from ptr over eligible VCs
// LK_HELD | packet body pending on lock_vc; only that VC may be selected
module vc_output_scheduler
  import vc_output_scheduler_pkg::*;
#(
  parameter int n       = N_VC_DEF,
  parameter int credits = CREDITS_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  vc_output_scheduler_if.master bus
);

  localparam int VW = (clog2(n) < 1) ? 1 : clog2(n);

  cnt_t          cnt     [n];
  cnt_t          cnt_nxt [n];
  logic [n-1:0]  ptr, ptr_nxt;
  logic [n-1:0]  lock_vc, lock_vc_nxt;
  lock_state_t   lk_st, lk_nxt;

  logic [n-1:0]  elig;
  logic [n-1:0]  grant;
  logic [n-1:0]  sel_c;
  logic [n-1:0]  pop_c;
  logic [n-1:0]  cred_hit;
  logic          popped;
  logic [VW-1:0] vc_bin;
  logic          cred_full;
  logic          pop_dry;

  always_comb begin
    elig     = '0;
    cred_hit = '0;
    for (int i = 0; i < n; i++) begin
      elig[i]     = !bus.vc_empty[i] && (cnt[i] != '0);
      cred_hit[i] = bus.credit_valid && (bus.credit_vc == VW'(i));
    end
  end

  vc_rr_arbiter #(.n(n)) u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    sel_c = grant;
    if (lk_st == LK_HELD) sel_c = lock_vc & elig;
  end

  assign pop_c  = bus.out_ready ? sel_c : '0;
  assign popped = |pop_c;

  always_comb begin
    vc_bin = '0;
    for (int i = 0; i < n; i++) begin
      if (sel_c[i]) vc_bin = VW'(i);
    end
  end

  assign bus.select     = rst_n ? sel_c  : '0;
  assign bus.pop        = rst_n ? pop_c  : '0;
  assign bus.flit_valid = rst_n & popped;
  assign bus.out_vc     = rst_n ? vc_bin : '0;

  // A pop and a returned credit on the same VC cancel out.
  always_comb begin
    for (int i = 0; i < n; i++) begin
      cnt_nxt[i] = cnt[i];
      case ({cred_hit[i], pop_c[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + cnt_t'(1);
        2'b01:   cnt_nxt[i] = cnt[i] - cnt_t'(1);
        default: cnt_nxt[i] = cnt[i];
      endcase
    end
  end

  always_comb begin
    lk_nxt      = lk_st;
    lock_vc_nxt = lock_vc;
    ptr_nxt     = ptr;
    if (popped) begin
`ifdef VC_SCHED_WORMHOLE_LOCK_EN
      if (!bus.head_tail) begin
        lk_nxt      = LK_HELD;
        lock_vc_nxt = sel_c;
      end else begin
        lk_nxt      = LK_OPEN;
        lock_vc_nxt = '0;
        ptr_nxt     = {sel_c[n-2:0], sel_c[n-1]};
      end
`else
      ptr_nxt = {sel_c[n-2:0], sel_c[n-1]};
`endif
    end
  end

`ifndef VC_SCHED_WORMHOLE_LOCK_EN
  logic unused_head_tail;
  assign unused_head_tail = bus.head_tail;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < n; i++) cnt[i] <= cnt_t'(credits);
      ptr     <= {{(n-1){1'b0}}, 1'b1};
      lk_st   <= LK_OPEN;
      lock_vc <= '0;
    end else begin
      for (int i = 0; i < n; i++) cnt[i] <= cnt_nxt[i];
      ptr     <= ptr_nxt;
      lk_st   <= lk_nxt;
      lock_vc <= lock_vc_nxt;
    end
  end

  always_comb begin
    cred_full = 1'b0;
    pop_dry   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cred_hit[i] && (cnt[i] == cnt_t'(credits))) cred_full = 1'b1;
      if (pop_c[i] && (cnt[i] == '0))                 pop_dry   = 1'b1;
    end
  end

  a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n) !cred_full)
    else $fatal(1, "credit returned to a VC already at full credit");
  a_pop_no_credit: assert property (@(posedge clk) disable iff (!rst_n) !pop_dry)
    else $fatal(1, "pop issued on a VC with zero credit");
  a_select_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_c))
    else $fatal(1, "select is not one-hot or zero");
  a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
                                   !$isunknown({bus.vc_empty, bus.out_ready, bus.credit_valid}))
    else $fatal(1, "unknown value on scheduler control inputs");

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Scoreboard bench for vc_output_scheduler: bank/downstream model, reference scheduler, pop monitor.
module tb_vc_output_scheduler;
  import vc_output_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int CR = 3;
  localparam int FD = 64;
`ifdef VC_SCHED_WORMHOLE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    int cyc;
    int vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_output_scheduler_if #(.n(N)) bus ();
  vc_output_scheduler #(.n(N), .credits(CR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bank model: per-VC circular FIFO of tail bits.
  bit fmem [N][FD];
  int frd [N];
  int fwr [N];
  int ds_held [N];

  // Reference scheduler state.
  int mcnt [N];
  int mptr;
  bit mlock;
  int mlvc;

  exp_t sb [$];
  int   obs [$];
  int   ntest = 0;
  int   nfail = 0;
  int   cyc = 0;

  function automatic int fsize(input int v);
    return fwr[v] - frd[v];
  endfunction

  function automatic bit ffront(input int v);
    return fmem[v][frd[v] % FD];
  endfunction

  function automatic void fpush(input int v, input bit t);
    fmem[v][fwr[v] % FD] = t;
    fwr[v]++;
  endfunction

  function automatic bit m_elig(input int v);
    return (fsize(v) > 0) && (mcnt[v] > 0);
  endfunction

  function automatic int m_select();
    if (mlock) return m_elig(mlvc) ? mlvc : -1;
    for (int k = 0; k < N; k++) begin
      if (m_elig((mptr + k) % N)) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_seq(input string name, input int exp_q[$]);
    check({name, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("%s_%0d", name, i), obs[i], exp_q[i]);
    end
  endtask

  // Monitor: every DUT flit is matched against the oldest predicted pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.flit_valid) begin
        obs.push_back(int'(bus.out_vc));
        check("pop_eq_select", int'(bus.pop), int'(bus.select));
        if (sb.size() == 0) begin
          check("unexpected_pop_vc", int'(bus.out_vc), -1);
        end else begin
          e = sb.pop_front();
          check("pop_vc", int'(bus.out_vc), e.vc);
          check("pop_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_pop_zero", int'(bus.pop), 0);
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          ntest++;
          nfail++;
          $display("FAIL missed_pop: got no flit expected vc %0d (cycle %0d)", e.vc, cyc);
        end
      end
    end
  end

  // cmode: 0 none, 1 credit on cvc_in, 2 credit whenever one is owed, 3 owed credit at random
  task automatic step(input bit rdy, input int cmode, input int cvc_in);
    int   cand[$];
    int   cv, cvc, ms, dsel, dp;
    exp_t t;
    cv  = 0;
    cvc = 0;
    if (cmode == 1) begin
      cv  = 1;
      cvc = cvc_in;
    end else if (cmode == 2 || (cmode == 3 && $urandom_range(1, 0) == 1)) begin
      for (int v = 0; v < N; v++) if (ds_held[v] > 0) cand.push_back(v);
      if (cand.size() > 0) begin
        cv  = 1;
        cvc = cand[$urandom_range(cand.size() - 1, 0)];
      end
    end
    for (int v = 0; v < N; v++) bus.vc_empty[v] = (fsize(v) == 0);
    bus.out_ready    = rdy;
    bus.credit_valid = cv[0];
    bus.credit_vc    = 2'(cvc);
    #1;
    dsel = -1;
    for (int v = 0; v < N; v++) if (bus.select[v]) dsel = v;
    bus.head_tail = (dsel >= 0 && fsize(dsel) > 0) ? ffront(dsel) : 1'b0;

    ms = m_select();
    if (rdy && ms >= 0) begin
      t.cyc = cyc;
      t.vc  = ms;
      sb.push_back(t);
      mcnt[ms]--;
      if (!LOCK_EN || ffront(ms)) begin
        mlock = 1'b0;
        mptr  = (ms + 1) % N;
      end else begin
        mlock = 1'b1;
        mlvc  = ms;
      end
    end
    if (cv != 0) mcnt[cvc]++;

    @(negedge clk);
    #1;
    dp = -1;
    for (int v = 0; v < N; v++) if (bus.pop[v]) dp = v;
    @(posedge clk);
    #1;
    cyc++;
    if (dp >= 0 && fsize(dp) > 0) begin
      frd[dp]++;
      ds_held[dp]++;
    end
    if (cv != 0) ds_held[cvc]--;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.vc_empty     = '0;
    bus.out_ready    = 1'b1;
    bus.credit_valid = 1'b0;
    bus.credit_vc    = '0;
    bus.head_tail    = 1'b0;
    for (int v = 0; v < N; v++) begin
      frd[v]     = 0;
      fwr[v]     = 0;
      ds_held[v] = 0;
      mcnt[v]    = CR;
    end
    mptr  = 0;
    mlock = 1'b0;
    mlvc  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_select", int'(bus.select), 0);
    check("rst_pop", int'(bus.pop), 0);
    check("rst_flit_valid", int'(bus.flit_valid), 0);
    check("rst_out_vc", int'(bus.out_vc), 0);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    obs.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int eq[$];
    int v, len;

    // First pop after reset comes from VC0.
    do_reset();
    for (int i = 0; i < N; i++) fpush(i, 1'b1);
    step(1'b1, 0, 0);
    eq = '{0};
    check_seq("first_pop", eq);

    // Round-robin over single-flit packets with steady credit return.
    do_reset();
    for (int i = 0; i < N; i++) begin
      fpush(i, 1'b1);
      fpush(i, 1'b1);
    end
    repeat (5) step(1'b1, 2, 0);
    eq = '{0, 1, 2, 3, 0};
    check_seq("rr_order", eq);

    // 3-flit packet on VC1 against a waiting VC2.
    do_reset();
    fpush(1, 1'b0); fpush(1, 1'b0); fpush(1, 1'b1);
    fpush(2, 1'b1); fpush(2, 1'b1);
    repeat (5) step(1'b1, 0, 0);
    if (LOCK_EN) eq = '{1, 1, 1, 2, 2};
    else         eq = '{1, 2, 1, 2, 1};
    check_seq("wormhole", eq);

    // Credit starvation on VC0, then one credit releases exactly one flit.
    do_reset();
    repeat (4) fpush(0, 1'b0);
    fpush(0, 1'b1);
    repeat (5) step(1'b1, 0, 0);
    check("starve_pops", obs.size(), 3);
    check("starve_select", int'(bus.select), 0);
    step(1'b1, 1, 0);
    check("starve_credit_cycle_pops", obs.size(), 3);
    step(1'b1, 0, 0);
    check("starve_resume_pops", obs.size(), 4);
    step(1'b1, 0, 0);
    check("starve_after_pops", obs.size(), 4);

    // Pop and credit on VC2 together leave its count unchanged.
    do_reset();
    repeat (5) fpush(2, 1'b1);
    step(1'b1, 0, 0);
    step(1'b1, 1, 2);
    repeat (4) step(1'b1, 0, 0);
    eq = '{2, 2, 2, 2};
    check_seq("pop_and_credit", eq);

    // Backpressure in the middle of a VC1 packet.
    do_reset();
    fpush(1, 1'b0); fpush(1, 1'b0); fpush(1, 1'b1);
    fpush(3, 1'b1);
    step(1'b1, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check("bp_hold_pops", obs.size(), 1);
    check("bp_select", int'(bus.select), LOCK_EN ? 32'h2 : 32'h8);
    repeat (4) step(1'b1, 0, 0);
    if (LOCK_EN) eq = '{1, 1, 1, 3};
    else         eq = '{1, 3, 1, 1};
    check_seq("backpressure", eq);

    // Random traffic against the reference scheduler.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        v   = $urandom_range(N - 1, 0);
        len = $urandom_range(4, 1);
        if (fsize(v) + len <= 40) begin
          for (int f = 0; f < len; f++) fpush(v, (f == len - 1));
        end
      end
      step($urandom_range(3, 0) != 0, 3, 0);
    end
    step(1'b0, 0, 0);
    check("random_sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
